prog_encoder: RTL
=================

# prog_encoder

Instruction encoder and program loader for the basic CPU: accepts assembled instruction fields over a valid/ready handshake, packs each one into the 16-bit instruction word that the CPU control unit decodes, and writes it sequentially into program memory. Sits between the test/boot host and the program-memory write port. Holds the CPU in reset while a program is being loaded.

## Interface
- `PC_W`, default 10: program-memory address width; depth is 2^PC_W.
- `clk` input, 1 bit: clock, rising edge.
- `reset` input, 1 bit: asynchronous, active-high.
- `start` input, 1 bit: one-cycle pulse; begins a load at address 0.
- `in_valid` input, 1 bit: instruction fields valid.
- `in_ready` output, 1 bit: encoder accepts the fields this cycle.
- `in_class` input, 2 bits: 00 ALU-immediate, 01 ALU-register, 10 jump, 11 illegal.
- `in_op` input, 3 bits: ALU op 0–6, or jump condition (0 always, 1 if z, 2 if not z).
- `in_rd`, `in_rs` input, 4 bits each: destination register and source register.
- `in_imm` input, 8 bits: immediate.
- `in_addr` input, PC_W bits: jump target.
- `in_last` input, 1 bit: final instruction of the program.
- `pm_we` output, 1 bit: program-memory write strobe.
- `pm_addr` output, PC_W bits: write address.
- `pm_wdata` output, 16 bits: encoded instruction.
- `cpu_hold` output, 1 bit: keeps the CPU in reset while high.
- `done` output, 1 bit: load finished; level, held until the next `start`.
- `err` output, 1 bit: sticky; set on an illegal field or an overflow, cleared by `start`.
- `count` output, PC_W+1 bits: number of words written.

## Operation
- **Encoding** (bits [15:10] hold the control-unit opcode):
  - ALU-immediate: {1, op[2:0], imm[7:0], rd}.
  - ALU-register: {010, op[2:0], 00, rs, rd}.
  - Jump: {0001, cond[1:0], addr}. Address bits above PC_W are zero.
- **Illegal** inputs: ALU op 7, jump cond 3, and class 11. An illegal instruction is accepted and writes 16'h0000 (the decoder's default no-write word), sets `err`, and still advances the address.
- **FSM** states: IDLE, LOAD, DONE.
  - IDLE → LOAD on `start`.
  - LOAD → DONE on an accepted beat with `in_last`, or on an accepted beat that writes address 2^PC_W−1.
  - DONE → LOAD on `start`.
- `start` in any state clears the address, `count`, `err` and `done`, and enters LOAD.
- If `start` arrives in the same cycle as an accepted beat, `start` wins and the beat is discarded.
- `in_ready` = 1 only in LOAD.
- **Overflow:** reaching the end of memory without `in_last` sets `err`. In DONE, `in_ready` = 0, so no further beats are accepted. The address never wraps.
- `cpu_hold` = 1 in IDLE and LOAD, 0 in DONE.

## Timing
- An accepted beat (`in_valid` & `in_ready` at a rising edge) is registered. On the next cycle, `pm_we` = 1 with `pm_addr` and `pm_wdata`: latency 1 cycle.
- Back-to-back beats give one write per cycle.
- `count` increments in the same cycle that `pm_we` is high.
- `done` and `cpu_hold` change one cycle after the last write strobe. The last write is therefore complete before the CPU leaves reset.
- **Reset values:**
  - `pm_we`, `done`, `err`, `in_ready` = 0.
  - `cpu_hold` = 1.
  - `pm_addr`, `pm_wdata`, `count` = 0.
  - State = IDLE.
- Reset asserted mid-load aborts the load immediately: a pending write strobe is dropped and no partial `done` is produced.

## Structure
- Shared package `cpu_pkg` holds:
  - Class codes.
  - Opcode prefixes: 1 for immediate, 010 for register, 0001 for jump.
  - ALU op codes 0–6.
  - Jump condition codes.
  - `INSTR_W` = 16.
- The control unit is to use the same package constants.
- Sub-module `instr_pack`: purely combinational fields → {word, illegal}. The FSM, address counter and output register live in the top.

## Test plan
- `start`, then three beats: IMM op 2 imm 8'h05 rd 3; REG op 3 rs 1 rd 2; JMP cond 1 addr 10'h004 `in_last`.
  - Writes: 16'hA053 @0, 16'h4C12 @1, 16'h1404 @2.
  - After the last write: `done` = 1, `cpu_hold` = 0, `count` = 3, `err` = 0.
- Illegal beat (ALU op 7) between two legal beats → 16'h0000 written at address 1, `err` = 1, address continues to 2.
- `in_valid` toggled every other cycle → no gaps or duplicates in `pm_addr`; `pm_we` pulses only for accepted beats.
- `PC_W` = 2, five beats offered, none with `in_last`:
  - Four writes, at addresses 0–3.
  - `err` = 1, `done` = 1.
  - Fifth beat is never accepted (`in_ready` = 0).
- Async `reset` pulse mid-load, with no clock edge during the pulse → outputs return to reset values immediately; after `start`, the load restarts from address 0.
- `start` in the same cycle as a valid beat → beat discarded, address stays 0; the next beat writes @0.

Source files
------------

// File: rtl/cpu_pkg.sv
// Shared definitions for the basic CPU: instruction classes, opcode prefixes,
// ALU op codes, jump conditions and the encoder's load-sequencer states.
package cpu_pkg;

  localparam int INSTR_W    = 16;
  localparam int JMP_ADDR_W = 10;

  // Instruction classes as presented by the assembler/host
  typedef enum logic [1:0] {
    CLS_IMM = 2'b00,
    CLS_REG = 2'b01,
    CLS_JMP = 2'b10,
    CLS_ILL = 2'b11
  } class_e;

  // Control-unit opcode prefixes occupying the top of the instruction word
  localparam logic       PFX_IMM = 1'b1;
  localparam logic [2:0] PFX_REG = 3'b010;
  localparam logic [3:0] PFX_JMP = 4'b0001;

  // ALU operations; code 7 is reserved and never encoded
  typedef enum logic [2:0] {
    ALU_ADD  = 3'd0,
    ALU_SUB  = 3'd1,
    ALU_AND  = 3'd2,
    ALU_OR   = 3'd3,
    ALU_XOR  = 3'd4,
    ALU_SHL  = 3'd5,
    ALU_SHR  = 3'd6,
    ALU_RSVD = 3'd7
  } alu_op_e;

  // Jump conditions; code 3 is reserved
  typedef enum logic [1:0] {
    JC_ALWAYS = 2'd0,
    JC_Z      = 2'd1,
    JC_NZ     = 2'd2,
    JC_RSVD   = 2'd3
  } jmp_cond_e;

  // Word that the decoder treats as a no-write instruction
  localparam logic [INSTR_W-1:0] NOP_WORD = '0;

  // Program loader sequencer
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LOAD = 2'd1,
    ST_DONE = 2'd2
  } enc_state_e;

endpackage

// File: rtl/instr_pack.sv
// Combinational instruction packer: assembled fields -> 16-bit control-unit word.
// Illegal field combinations produce the no-write word and raise illegal.
module instr_pack
  import cpu_pkg::*;
#(
  parameter int PC_W = 10
) (
  input  logic [1:0]         in_class,
  input  logic [2:0]         in_op,
  input  logic [3:0]         in_rd,
  input  logic [3:0]         in_rs,
  input  logic [7:0]         in_imm,
  input  logic [PC_W-1:0]    in_addr,
  output logic [INSTR_W-1:0] word,
  output logic               illegal
);

  logic [JMP_ADDR_W-1:0] jaddr;

  // Jump target field: zero-extended (or truncated) program address
  assign jaddr = JMP_ADDR_W'(in_addr);

  // Select the field layout by class and flag reserved codes
  always_comb begin
    word    = NOP_WORD;
    illegal = 1'b0;
    case (in_class)
      CLS_IMM: begin
        if (in_op == ALU_RSVD) illegal = 1'b1;
        else                   word = {PFX_IMM, in_op, in_imm, in_rd};
      end
      CLS_REG: begin
        if (in_op == ALU_RSVD) illegal = 1'b1;
        else                   word = {PFX_REG, in_op, 2'b00, in_rs, in_rd};
      end
      CLS_JMP: begin
        // Only conditions 0..2 exist; any larger op value is reserved
        if (in_op > {1'b0, JC_NZ}) illegal = 1'b1;
        else                       word = {PFX_JMP, in_op[1:0], jaddr};
      end
      default: illegal = 1'b1;
    endcase
  end

endmodule

// File: rtl/prog_encoder.sv
// Program loader: accepts instruction fields over valid/ready, packs them and
// writes them sequentially into program memory while holding the CPU in reset.
module prog_encoder
  import cpu_pkg::*;
#(
  parameter int PC_W = 10
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               start,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [1:0]         in_class,
  input  logic [2:0]         in_op,
  input  logic [3:0]         in_rd,
  input  logic [3:0]         in_rs,
  input  logic [7:0]         in_imm,
  input  logic [PC_W-1:0]    in_addr,
  input  logic               in_last,
  output logic               pm_we,
  output logic [PC_W-1:0]    pm_addr,
  output logic [INSTR_W-1:0] pm_wdata,
  output logic               cpu_hold,
  output logic               done,
  output logic               err,
  output logic [PC_W:0]      count
);

  enc_state_e          state, state_nx;
  logic [PC_W-1:0]     addr;
  logic                closing;
  logic                accept;
  logic                at_end;
  logic                finishing;
  logic [INSTR_W-1:0]  word;
  logic                illegal;

  instr_pack #(.PC_W(PC_W)) u_pack (
    .in_class (in_class),
    .in_op    (in_op),
    .in_rd    (in_rd),
    .in_rs    (in_rs),
    .in_imm   (in_imm),
    .in_addr  (in_addr),
    .word     (word),
    .illegal  (illegal)
  );

  // A start in the same cycle as a handshake discards that beat
  assign accept    = in_valid && in_ready && !start;
  assign at_end    = (addr == {PC_W{1'b1}});
  assign finishing = in_last || at_end;

  // State register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= ST_IDLE;
    else       state <= state_nx;
  end

  // Next state: leave LOAD only after the final write strobe has been issued
  always_comb begin
    state_nx = state;
    if (start) begin
      state_nx = ST_LOAD;
    end else begin
      case (state)
        ST_LOAD: if (closing) state_nx = ST_DONE;
        default: state_nx = state;
      endcase
    end
  end

  // State-decoded outputs; ready drops while the final write is in flight
  always_comb begin
    in_ready = (state == ST_LOAD) && !closing;
    cpu_hold = (state != ST_DONE);
    done     = (state == ST_DONE);
  end

  // Write port, address counter, word count and sticky error
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pm_we    <= 1'b0;
      pm_addr  <= '0;
      pm_wdata <= '0;
      addr     <= '0;
      count    <= '0;
      err      <= 1'b0;
      closing  <= 1'b0;
    end else if (start) begin
      pm_we    <= 1'b0;
      addr     <= '0;
      count    <= '0;
      err      <= 1'b0;
      closing  <= 1'b0;
    end else begin
      pm_we   <= accept;
      closing <= accept && finishing;
      if (accept) begin
        pm_addr  <= addr;
        pm_wdata <= word;
        addr     <= addr + 1'b1;
        count    <= count + 1'b1;
        err      <= err | illegal | (at_end && !in_last);
      end
    end
  end

endmodule
